seven_seg_reader: RTL and testbench

- Monitor/decoder for the time-multiplexed, active-low 7-segment display bus: the inverse of the team's hex-to-segment encoder.
- Samples the segment lines and the active-low anode enables.
- Qualifies each digit's pattern for stability, then decodes it back to a 4-bit hex value per digit.
- Used on-chip as a display loopback checker and in benches as a bus-level scoreboard source.

---
 rtl/seven_seg_pkg.sv | 21 ++
 rtl/seven_seg_decode.sv | 25 ++
 rtl/seven_seg_reader.sv | 168 ++++++++++++++++
 tb/tb_seven_seg_reader.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants for the 7-segment display bus (encoder and reader).
// Segment patterns are active-low, bit6=g .. bit0=a.
package seven_seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Index = hex value; entry 15 is leftmost.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h18, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } seg_state_e;

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational segment-pattern to hex decoder.
// Flags legal hex glyphs and the all-off blank pattern.
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] i_pattern,
  output logic [3:0] o_hex,
  output logic       o_legal,
  output logic       o_blank
);

  // Reverse lookup through the shared glyph table.
  always_comb begin
    o_hex   = '0;
    o_legal = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i_pattern == SEG_LUT[i]) begin
        o_hex   = 4'(i);
        o_legal = 1'b1;
      end
    end
    o_blank = (i_pattern == SEG_BLANK);
  end

endmodule

// File: rtl/seven_seg_reader.sv
// Monitor for the multiplexed active-low 7-segment bus.
// Optional err_count output enabled by SEVEN_SEG_ERRCNT_EN.
module seven_seg_reader
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [6:0]                seg,
  input  logic [NUM_DIGITS-1:0]     an,
  output logic [4*NUM_DIGITS-1:0]   digits,
  output logic [NUM_DIGITS-1:0]     digit_valid,
  output logic                      update,
  output logic                      err,
`ifdef SEVEN_SEG_ERRCNT_EN
  output logic [7:0]                err_count,
`endif
  output logic [6:0]                err_pattern
);

  localparam int SW   = NUM_DIGITS + 7;
  localparam int CW   = $clog2(STABLE_CYCLES + 1);
  localparam int SELW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] STAB = CW'(STABLE_CYCLES);

  logic [SW-1:0]                 r_sample;
  logic [SW-1:0]                 r_prev;
  logic [CW-1:0]                 r_cnt;
  seg_state_e                    r_state;
  logic [NUM_DIGITS-1:0][3:0]    r_digits;
  logic [NUM_DIGITS-1:0]         r_valid;
  logic                          r_update;
  logic                          r_err;
  logic [6:0]                    r_err_pat;

  logic [NUM_DIGITS-1:0]         w_an;
  logic [6:0]                    w_seg;
  logic                          w_change;
  logic                          w_one_hot;
  logic [SELW-1:0]               w_sel;
  logic [CW-1:0]                 w_cnt_nxt;
  seg_state_e                    w_state_nxt;
  logic                          w_capture;
  logic                          w_eval;
  logic [3:0]                    w_hex;
  logic                          w_legal;
  logic                          w_blank;
  logic                          w_illegal;

  assign w_an      = r_sample[SW-1:7];
  assign w_seg     = r_sample[6:0];
  assign w_change  = (r_sample != r_prev);
  assign w_one_hot = $onehot(~w_an);
  assign w_illegal = !w_legal && !w_blank;

  seven_seg_decode u_dec (
    .i_pattern (w_seg),
    .o_hex     (w_hex),
    .o_legal   (w_legal),
    .o_blank   (w_blank)
  );

  // Register the bus and keep the previous sample for change detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sample <= '1;
      r_prev   <= '1;
    end else begin
      r_prev   <= r_sample;
      r_sample <= {an, seg};
    end
  end

  // Locate the single low anode; only meaningful when one-hot.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!w_an[i]) w_sel = SELW'(i);
    end
  end

  // Stability count: restart at 1 on change, else saturate.
  always_comb begin
    if (w_change)
      w_cnt_nxt = CW'(1);
    else if (r_cnt == STAB)
      w_cnt_nxt = r_cnt;
    else
      w_cnt_nxt = r_cnt + CW'(1);
  end

  // Stability counter register.
  always_ff @(posedge clk) begin
    if (reset) r_cnt <= '0;
    else       r_cnt <= w_cnt_nxt;
  end

  // Qualification FSM: next state and capture strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_eval      = 1'b0;
    unique case (r_state)
      IDLE:    w_eval = 1'b1;
      SETTLE:  w_eval = 1'b1;
      HOLD:    w_eval = w_change;
      default: w_eval = 1'b1;
    endcase
    if (w_eval) begin
      if (!w_one_hot) begin
        w_state_nxt = IDLE;
      end else if (w_cnt_nxt == STAB) begin
        w_state_nxt = HOLD;
        w_capture   = 1'b1;
      end else begin
        w_state_nxt = SETTLE;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Write the selected digit and raise the one-cycle pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_digits  <= '0;
      r_valid   <= '0;
      r_update  <= 1'b0;
      r_err     <= 1'b0;
      r_err_pat <= SEG_BLANK;
    end else begin
      r_update <= w_capture;
      r_err    <= w_capture && w_illegal;
      if (w_capture) begin
        r_valid[w_sel] <= w_legal;
        if (w_legal) r_digits[w_sel] <= w_hex;
        if (w_illegal) r_err_pat <= w_seg;
      end
    end
  end

`ifdef SEVEN_SEG_ERRCNT_EN
  logic [7:0] r_err_cnt;

  // Saturating count of illegal captures.
  always_ff @(posedge clk) begin
    if (reset)
      r_err_cnt <= '0;
    else if (w_capture && w_illegal && r_err_cnt != 8'hFF)
      r_err_cnt <= r_err_cnt + 8'd1;
  end

  assign err_count = r_err_cnt;
`endif

  assign digits      = r_digits;
  assign digit_valid = r_valid;
  assign update      = r_update;
  assign err         = r_err;
  assign err_pattern = r_err_pat;

endmodule

// File: tb/tb_seven_seg_reader.sv
// Directed bench for seven_seg_reader (default parameters).
// Checks err_count too when SEVEN_SEG_ERRCNT_EN is defined.
module tb_seven_seg_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] seg;
  logic [1:0] an;
  logic [7:0] digits;
  logic [1:0] digit_valid;
  logic       update;
  logic       err;
  logic [6:0] err_pattern;
`ifdef SEVEN_SEG_ERRCNT_EN
  logic [7:0] err_count;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int n_upd;
  int n_err;

  seven_seg_reader #(
    .NUM_DIGITS    (2),
    .STABLE_CYCLES (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .seg         (seg),
    .an          (an),
    .digits      (digits),
    .digit_valid (digit_valid),
    .update      (update),
    .err         (err),
`ifdef SEVEN_SEG_ERRCNT_EN
    .err_count   (err_count),
`endif
    .err_pattern (err_pattern)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic dwell(input logic [1:0] a, input logic [6:0] s,
                       input int n);
    an  = a;
    seg = s;
    n_upd = 0;
    n_err = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (update) n_upd++;
      if (err) n_err++;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_digits"}, 32'(digits), 32'h00);
    check({tag, "_valid"}, 32'(digit_valid), 32'h0);
    check({tag, "_update"}, 32'(update), 32'h0);
    check({tag, "_err"}, 32'(err), 32'h0);
    check({tag, "_errpat"}, 32'(err_pattern), 32'h7F);
  endtask

  initial begin
    reset = 1'b1;
    an    = 2'b11;
    seg   = 7'h7F;
    repeat (3) tick();
    reset = 1'b0;
    check_reset_vals("rst");
`ifdef SEVEN_SEG_ERRCNT_EN
    check("rst_errcnt", 32'(err_count), 32'h0);
`endif

    // Digit 0 shows 3: capture lands on the 5th edge.
    an  = 2'b10;
    seg = 7'h30;
    for (int e = 0; e < 4; e++) begin
      tick();
      check($sformatf("lat_noupd_e%0d", e), 32'(update), 32'h0);
    end
    tick();
    check("lat_upd", 32'(update), 32'h1);
    check("lat_digits", 32'(digits), 32'h03);
    check("lat_valid", 32'(digit_valid), 32'h1);
    tick();
    check("lat_pulse_end", 32'(update), 32'h0);
    dwell(2'b10, 7'h30, 4);
    check("hold_noupd", 32'(n_upd), 32'd0);
    check("hold_dig1", 32'(digits[7:4]), 32'h0);

    // Alternate A on digit 0 and F on digit 1.
    for (int r = 0; r < 2; r++) begin
      dwell(2'b10, 7'h08, 8);
      check($sformatf("alt_d0_upd_r%0d", r), 32'(n_upd), 32'd1);
      dwell(2'b01, 7'h0E, 8);
      check($sformatf("alt_d1_upd_r%0d", r), 32'(n_upd), 32'd1);
    end
    check("alt_digits", 32'(digits), 32'hFA);
    check("alt_valid", 32'(digit_valid), 32'h3);

    // Toggling pattern never qualifies.
    n_upd = 0;
    an = 2'b10;
    for (int k = 0; k < 20; k++) begin
      seg = ((k / 2) % 2 == 0) ? 7'h00 : 7'h40;
      tick();
      if (update) n_upd++;
    end
    check("toggle_noupd", 32'(n_upd), 32'd0);
    dwell(2'b10, 7'h00, 5);
    check("settle8_upd", 32'(update), 32'h1);
    check("settle8_digits", 32'(digits), 32'hF8);

    // Two anodes low: ghosting, no capture.
    dwell(2'b00, 7'h30, 10);
    check("ghost_upd", 32'(n_upd), 32'd0);
    check("ghost_err", 32'(n_err), 32'd0);
    check("ghost_digits", 32'(digits), 32'hF8);
    check("ghost_valid", 32'(digit_valid), 32'h3);

    // Illegal pattern after a valid 3.
    dwell(2'b10, 7'h30, 6);
    check("pre_err_digits", 32'(digits), 32'hF3);
    dwell(2'b10, 7'h7E, 5);
    check("ill_err_now", 32'(err), 32'h1);
    check("ill_err_cnt", 32'(n_err), 32'd1);
    check("ill_upd_cnt", 32'(n_upd), 32'd1);
    check("ill_errpat", 32'(err_pattern), 32'h7E);
    check("ill_valid", 32'(digit_valid), 32'h2);
    check("ill_digits", 32'(digits), 32'hF3);
    tick();
    check("ill_err_pulse_end", 32'(err), 32'h0);
`ifdef SEVEN_SEG_ERRCNT_EN
    check("ill_errcount1", 32'(err_count), 32'd1);
`endif

    // Blank pattern: update without err.
    dwell(2'b10, 7'h30, 6);
    check("reval_valid", 32'(digit_valid), 32'h3);
    dwell(2'b10, 7'h7F, 5);
    check("blank_err", 32'(n_err), 32'd0);
    check("blank_upd", 32'(n_upd), 32'd1);
    check("blank_valid", 32'(digit_valid), 32'h2);
    check("blank_digits", 32'(digits), 32'hF3);
    check("blank_errpat", 32'(err_pattern), 32'h7E);

`ifdef SEVEN_SEG_ERRCNT_EN
    for (int k = 0; k < 300; k++)
      dwell(2'b10, (k % 2 == 0) ? 7'h7D : 7'h7E, 5);
    tick();
    check("errcount_sat", 32'(err_count), 32'd255);
`endif

    // Reset while the counter sits at 3.
    an  = 2'b01;
    seg = 7'h12;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    check_reset_vals("midrst");
`ifdef SEVEN_SEG_ERRCNT_EN
    check("midrst_errcnt", 32'(err_count), 32'h0);
`endif
    reset = 1'b0;
    for (int e = 0; e < 4; e++) begin
      tick();
      check($sformatf("requal_noupd_e%0d", e), 32'(update), 32'h0);
    end
    tick();
    check("requal_upd", 32'(update), 32'h1);
    check("requal_digits", 32'(digits), 32'h50);
    check("requal_valid", 32'(digit_valid), 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
